// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: upstream sequencer for the SPI master core.
// Buffers outgoing {last, data} words in a TX FIFO and issues one core start
// per word. Each received word is captured into an RX FIFO. The active-low chip
// select stays low across a burst, which is closed by a word tagged as last.
module spi_burst_ctrl #(
   parameter int unsigned WordLength   = 8,
   parameter int unsigned Depth        = 8,
   parameter int unsigned CsIdleCycles = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [WordLength-1:0] tx_data_i,
   input  logic                  tx_last_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [WordLength-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   output logic [WordLength-1:0] core_din_o,
   output logic                  core_start_o,
   input  logic                  core_ready_i,
   input  logic [WordLength-1:0] core_dout_i,
   input  logic                  core_done_tick_i,
   output logic                  ss_n_o,
   output logic                  busy_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam int unsigned CW = $clog2(CsIdleCycles) + 1;
   localparam logic [AW:0]   FifoFull = (AW+1)'(Depth);
   localparam logic [CW-1:0] CntLast  = CW'(CsIdleCycles - 1);

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      ISSUE,
      WAIT,
      CS_HOLD
   } state_e;

   // ---------------- TX FIFO ----------------
   logic [WordLength:0]   tx_mem_q [Depth];
   logic [AW-1:0]         tx_wr_q, tx_rd_q;
   logic [AW:0]           tx_cnt_q;
   logic                  tx_full, tx_empty, tx_push, tx_pop;
   logic [WordLength-1:0] tx_head_data;
   logic                  tx_head_last;

   assign tx_full    = (tx_cnt_q == FifoFull);
   assign tx_empty   = (tx_cnt_q == '0);
   assign tx_ready_o = ~tx_full;
   assign tx_push    = tx_valid_i & ~tx_full;
   assign {tx_head_last, tx_head_data} = tx_mem_q[tx_rd_q];

   // TX storage write; contents need no reset since the count gates reads
   always_ff @(posedge clk_i) begin
      if (tx_push) begin
         tx_mem_q[tx_wr_q] <= {tx_last_i, tx_data_i};
      end
   end

   // TX pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
         if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt_q <= tx_cnt_q + (AW+1)'(1);
            2'b01:   tx_cnt_q <= tx_cnt_q - (AW+1)'(1);
            default: tx_cnt_q <= tx_cnt_q;
         endcase
      end
   end

   // ---------------- RX FIFO ----------------
   logic [WordLength-1:0] rx_mem_q [Depth];
   logic [AW-1:0]         rx_wr_q, rx_rd_q;
   logic [AW:0]           rx_cnt_q;
   logic                  rx_free, rx_push, rx_pop;

   state_e state_q, state_d;

   assign rx_free    = (rx_cnt_q != FifoFull);
   assign rx_valid_o = (rx_cnt_q != '0);
   assign rx_data_o  = rx_mem_q[rx_rd_q];
   assign rx_push    = (state_q == WAIT) & core_done_tick_i;
   assign rx_pop     = rx_valid_o & rx_ready_i;

   // RX storage write
   always_ff @(posedge clk_i) begin
      if (rx_push) begin
         rx_mem_q[rx_wr_q] <= core_dout_i;
      end
   end

   // RX pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
         if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt_q <= rx_cnt_q + (AW+1)'(1);
            2'b01:   rx_cnt_q <= rx_cnt_q - (AW+1)'(1);
            default: rx_cnt_q <= rx_cnt_q;
         endcase
      end
   end

   // ---------------- Sequencer FSM ----------------
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ss_n_q, ss_n_d;
   logic                  start_q, start_d;
   logic [WordLength-1:0] din_q, din_d;
   logic                  last_q, last_d;

   assign ss_n_o       = ss_n_q;
   assign core_start_o = start_q;
   assign core_din_o   = din_q;
   assign busy_o       = (state_q != IDLE);

   // State and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ss_n_q  <= 1'b1;
         start_q <= 1'b0;
         din_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ss_n_q  <= ss_n_d;
         start_q <= start_d;
         din_q   <= din_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic; the RX slot for the in-flight word is reserved at ISSUE
   // because nothing else can push RX until that word completes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ss_n_d  = ss_n_q;
      start_d = 1'b0;
      din_d   = din_q;
      last_d  = last_q;
      tx_pop  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!tx_empty) begin
               state_d = CS_SETUP;
               ss_n_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         CS_SETUP: begin
            if (cnt_q == CntLast) begin
               state_d = ISSUE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ISSUE: begin
            if (core_ready_i && !tx_empty && rx_free) begin
               start_d = 1'b1;
               din_d   = tx_head_data;
               last_d  = tx_head_last;
               tx_pop  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (core_done_tick_i) begin
               if (last_q) begin
                  state_d = CS_HOLD;
                  cnt_d   = '0;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         CS_HOLD: begin
            if (cnt_q == CntLast) begin
               ss_n_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: behavioural core model plus a queue-based reference
// of word order, chip-select framing and latency.
module tb_spi_burst_ctrl;

   localparam int unsigned WL    = 8;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CSI   = 2;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [WL-1:0] tx_data_i;
   logic          tx_last_i;
   logic          tx_valid_i;
   logic          tx_ready_o;
   logic [WL-1:0] rx_data_o;
   logic          rx_valid_o;
   logic          rx_ready_i;
   logic [WL-1:0] core_din_o;
   logic          core_start_o;
   logic          core_ready_i;
   logic [WL-1:0] core_dout_i;
   logic          core_done_tick_i;
   logic          ss_n_o;
   logic          busy_o;

   always #5 clk = ~clk;

   spi_burst_ctrl #(
      .WordLength  (WL),
      .Depth       (DEPTH),
      .CsIdleCycles(CSI)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .tx_data_i       (tx_data_i),
      .tx_last_i       (tx_last_i),
      .tx_valid_i      (tx_valid_i),
      .tx_ready_o      (tx_ready_o),
      .rx_data_o       (rx_data_o),
      .rx_valid_o      (rx_valid_o),
      .rx_ready_i      (rx_ready_i),
      .core_din_o      (core_din_o),
      .core_start_o    (core_start_o),
      .core_ready_i    (core_ready_i),
      .core_dout_i     (core_dout_i),
      .core_done_tick_i(core_done_tick_i),
      .ss_n_o          (ss_n_o),
      .busy_o          (busy_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- core model ----------------
   logic          core_hold = 1'b0;
   bit            cbusy = 1'b0;
   int            remain = 0;
   logic [WL-1:0] clatch;

   initial begin
      core_ready_i     = 1'b1;
      core_done_tick_i = 1'b0;
      core_dout_i      = '0;
      forever begin
         @(posedge clk);
         #1;
         core_done_tick_i = 1'b0;
         if (core_start_o) chk("core_idle_at_start", 32'(cbusy), 0);
         if (cbusy) begin
            remain--;
            if (remain == 0) begin
               core_done_tick_i = 1'b1;
               core_dout_i      = ~clatch;
               cbusy            = 1'b0;
            end
         end else if (core_start_o) begin
            clatch = core_din_o;
            cbusy  = 1'b1;
            remain = 10;
         end
         core_ready_i = !cbusy && !core_hold;
      end
   end

   // ---------------- RX consumer ----------------
   int rx_mode = 0;   // 0: always ready, 1: random, 2: never ready
   initial begin
      rx_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rx_mode)
            0:       rx_ready_i = 1'b1;
            1:       rx_ready_i = ($urandom_range(0, 9) < 7);
            default: rx_ready_i = 1'b0;
         endcase
      end
   end

   // ---------------- reference model / monitor ----------------
   logic [WL:0]   txq[$];
   logic [WL-1:0] exp_rxq[$];
   int   outstanding = 0, started = 0, rx_got = 0, ss_rises = 0;
   logic last_started = 1'b0;
   logic prev_ss = 1'b1, prev_start = 1'b0, prev_rxv = 1'b0, prev_rst = 1'b1;
   int   push_cyc, ss_fall_cyc, start_cyc, done_cyc, ss_rise_cyc, rxv_rise_cyc;

   initial begin
      logic [WL:0] hd;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            txq.delete();
            exp_rxq.delete();
            outstanding = 0;
         end else begin
            if (tx_valid_i && tx_ready_o) begin
               txq.push_back({tx_last_i, tx_data_i});
               push_cyc = cyc;
            end
            if (core_start_o) begin
               chk("start_width", 32'(prev_start), 0);
               chk("start_cs", 32'(ss_n_o), 0);
               if (txq.size() == 0) begin
                  chk("start_unexpected", 1, 0);
               end else begin
                  hd = txq.pop_front();
                  chk("start_din", 32'(core_din_o), 32'(hd[WL-1:0]));
                  exp_rxq.push_back(~hd[WL-1:0]);
                  last_started = hd[WL];
               end
               outstanding++;
               started++;
               start_cyc = cyc;
            end
            if (core_done_tick_i && outstanding > 0) begin
               outstanding--;
               done_cyc = cyc;
            end
            if (rx_valid_o && rx_ready_i) begin
               if (exp_rxq.size() == 0) chk("rx_unexpected", 1, 0);
               else chk("rx_data", 32'(rx_data_o), 32'(exp_rxq.pop_front()));
               rx_got++;
            end
            if (!prev_rst && !prev_ss && ss_n_o) begin
               chk("cs_release_last", 32'(last_started), 1);
               chk("cs_release_pending", outstanding, 0);
               ss_rise_cyc = cyc;
               ss_rises++;
            end
            if (prev_ss && !ss_n_o) ss_fall_cyc = cyc;
            if (!prev_rxv && rx_valid_o) rxv_rise_cyc = cyc;
         end
         prev_ss    = ss_n_o;
         prev_start = core_start_o;
         prev_rxv   = rx_valid_o;
         prev_rst   = rst_i;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_word(input logic [WL-1:0] d, input logic l);
      bit ok = 1'b0;
      @(posedge clk);
      #1;
      tx_data_i  = d;
      tx_last_i  = l;
      tx_valid_i = 1'b1;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         ok = tx_ready_o;
      end
      @(posedge clk);
      #1;
      tx_valid_i = 1'b0;
      if (!ok) chk("push_timeout", 0, 1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      bit ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge clk);
         ok = (txq.size() == 0) && (exp_rxq.size() == 0) && (outstanding == 0) &&
              !busy_o && ss_n_o && !rx_valid_o;
      end
      chk({tag, "_idle"}, 32'(ok), 1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int s, r, words, len;
      bit acc, rxv, ok;
      rst_i      = 1'b1;
      tx_valid_i = 1'b0;
      tx_data_i  = '0;
      tx_last_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("rst_ss_n", 32'(ss_n_o), 1);
      chk("rst_start", 32'(core_start_o), 0);
      chk("rst_din", 32'(core_din_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_rx_valid", 32'(rx_valid_o), 0);
      chk("rst_tx_ready", 32'(tx_ready_o), 1);

      // single word, latency and CS framing
      r = rx_got;
      push_word(8'hA5, 1'b1);
      wait_idle("single", 200);
      chk("single_ss_fall", 32'(ss_fall_cyc - push_cyc), 2);
      chk("single_start", 32'(start_cyc - push_cyc), 3 + CSI);
      chk("single_cs_hold", 32'(ss_rise_cyc - done_cyc), 1 + CSI);
      chk("single_rx_lat", 32'(rxv_rise_cyc - done_cyc), 1);
      chk("single_rx_count", 32'(rx_got - r), 1);

      // four-word burst under one chip select
      s = started; r = rx_got; words = ss_rises;
      for (int i = 0; i < 4; i++) push_word(WL'(i + 1), i == 3);
      wait_idle("burst", 300);
      chk("burst_starts", 32'(started - s), 4);
      chk("burst_rx_count", 32'(rx_got - r), 4);
      chk("burst_cs_releases", 32'(ss_rises - words), 1);

      // RX back-pressure: Depth transfers, then stall in ISSUE
      rx_mode = 2;
      s = started; r = rx_got;
      for (int i = 0; i < DEPTH + 2; i++) push_word(WL'(8'h10 + i), i == DEPTH + 1);
      wait_cycles(100);
      @(negedge clk);
      chk("rxbp_starts", 32'(started - s), DEPTH);
      chk("rxbp_ss_n", 32'(ss_n_o), 0);
      chk("rxbp_busy", 32'(busy_o), 1);
      chk("rxbp_rx_got", 32'(rx_got - r), 0);
      rx_mode = 0;
      wait_idle("rxbp", 600);
      chk("rxbp_total_rx", 32'(rx_got - r), DEPTH + 2);
      chk("rxbp_total_starts", 32'(started - s), DEPTH + 2);

      // core not ready: TX fills at Depth and refuses one more
      core_hold = 1'b1;
      wait_cycles(1);
      s = started;
      for (int i = 0; i < DEPTH; i++) push_word(WL'(8'h40 + i), i == DEPTH - 1);
      @(posedge clk);
      #1;
      tx_data_i  = 8'hEE;
      tx_last_i  = 1'b1;
      tx_valid_i = 1'b1;
      acc = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (tx_ready_o) acc = 1'b1;
      end
      chk("full_tx_ready", 32'(tx_ready_o), 0);
      @(posedge clk);
      #1 tx_valid_i = 1'b0;
      chk("full_extra_refused", 32'(acc), 0);
      chk("full_no_start", 32'(started - s), 0);
      core_hold = 1'b0;
      wait_idle("full", 600);
      chk("full_starts", 32'(started - s), DEPTH);

      // reset while waiting for the core
      s = started; r = rx_got;
      push_word(8'h3C, 1'b1);
      for (int n = 0; n < 100 && started == s; n++) @(negedge clk);
      chk("rstw_started", 32'(started - s), 1);
      wait_cycles(3);
      rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("rstw_ss_n", 32'(ss_n_o), 1);
      chk("rstw_busy", 32'(busy_o), 0);
      chk("rstw_rx_valid", 32'(rx_valid_o), 0);
      chk("rstw_tx_ready", 32'(tx_ready_o), 1);
      chk("rstw_start", 32'(core_start_o), 0);
      rxv = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (rx_valid_o) rxv = 1'b1;
      end
      chk("rstw_stale_done", 32'(rxv), 0);
      chk("rstw_rx_got", 32'(rx_got - r), 0);

      // TX underrun mid-burst keeps CS low until the last word arrives
      s = started; r = rx_got;
      for (int i = 0; i < 3; i++) push_word(WL'(8'h70 + i), 1'b0);
      wait_cycles(80);
      @(negedge clk);
      chk("underrun_starts", 32'(started - s), 3);
      chk("underrun_rx", 32'(rx_got - r), 3);
      chk("underrun_ss_n", 32'(ss_n_o), 0);
      chk("underrun_busy", 32'(busy_o), 1);
      push_word(8'h99, 1'b1);
      wait_idle("underrun", 200);
      chk("underrun_total", 32'(started - s), 4);
      chk("underrun_ss_n_end", 32'(ss_n_o), 1);

      // randomized bursts with random RX back-pressure and push gaps
      rx_mode = 1;
      r = rx_got; words = 0;
      for (int b = 0; b < 12; b++) begin
         len = $urandom_range(1, 5);
         for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            push_word(WL'($urandom), i == len - 1);
            words++;
         end
      end
      rx_mode = 0;
      wait_idle("rand", 1000);
      chk("rand_rx_count", 32'(rx_got - r), 32'(words));

      ok = (bad == 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
